rank_select: RTL and testbench
==============================

RANK_SELECT -- requirements
Module: rank_select

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, sample width.
REQ-002 SHALL have parameter N, default 7, maximum window size; odd, >= 3.
REQ-003 SHALL have parameter RANK_BITS, default $clog2(N+1), rank field width.
REQ-004 SHALL have port clk  input  1  clock; all logic on the rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  rank/sample set offered.
REQ-007 SHALL have port in_ready  output  1  set accepted when in_valid && in_ready.
REQ-008 SHALL have port ranks  input  RANK_BITS*N  per-slot rank.
- Slot i occupies bits [i*RANK_BITS +: RANK_BITS].
- Ranks are 1-based; 0 marks an inactive slot.
REQ-009 SHALL have port samples  input  DATA_BITS*N  per-slot sample, slot-aligned with ranks.
REQ-010 SHALL have port k  input  (N-3)/2  thermometer window control.
- Active window W = 3 + 2*popcount(k).
REQ-011 SHALL have port use_median  input  1  1: target = (W+1)/2; 0: target = rank_sel.
REQ-012 SHALL have port rank_sel  input  RANK_BITS  explicit target rank.
REQ-013 SHALL have port out_valid  output  1  result available.
REQ-014 SHALL have port out_ready  input  1  consumer accepts result.
REQ-015 SHALL have port out_data  output  DATA_BITS  selected sample.
REQ-016 SHALL have port out_err  output  1  result flagged invalid.

Function
REQ-017 SHALL be a 2-stage valid/ready pipeline with throughput one set per cycle.
- Stage A registers: match one-hot, samples, error bit.
- Stage B registers: selected data, error bit.
REQ-018 SHALL have latency of exactly 2 cycles from input handshake to out_valid when out_ready is held high.
REQ-019 SHALL compute the target rank and W from k, use_median and rank_sel sampled at the input handshake.
REQ-020 SHALL set match bit i when ranks slot i equals target and is nonzero.
REQ-021 SHALL select the lowest-index matching slot when more than one slot matches.
REQ-022 SHALL raise out_err and set out_data to 0 under either condition:
- zero slots match;
- target == 0 or target > W.
REQ-023 SHALL raise out_err when more than one slot matches; out_data SHALL still carry the selected sample.
REQ-024 SHALL hold out_data and out_err stable while out_valid && !out_ready.
REQ-025 SHALL drive in_ready = !A_valid || !B_valid || out_ready.
- A stage advances whenever its downstream slot is empty or draining in the same cycle.
REQ-026 SHALL overwrite a full stage on a simultaneous input accept and output drain, without a bubble and without loss.
REQ-027 SHALL ignore ranks and samples while in_valid is low or in_ready is low.

Reset
REQ-028 SHALL, while rst is low, clear all valid bits, out_data, out_err and internal registers to 0.
REQ-029 SHALL, when rst is asserted mid-operation, discard in-flight sets; none SHALL appear after release.
REQ-030 SHALL drive in_ready high in the first cycle after rst release.

Configuration
REQ-031 SHALL use macro RANK_SELECT_ERR_CNT_EN to compile the error counter in or out.
- Defined: adds output err_cnt, 8 bits, saturating at 255.
- err_cnt increments once per output handshake with out_err high.
- err_cnt clears on reset.
- Undefined: no err_cnt port; out_err still functional.

Structure
REQ-032 SHALL place shared definitions in package wos_pkg:
- rank-width function;
- window-size function W(k);
- median-target function.
REQ-033 SHALL implement the one-hot match and priority select in sub-module rank_match; all pipeline registers SHALL be in rank_select.

Verification (N=7, DATA_BITS=8)
REQ-034 SHALL cover basic median selection:
- k=00, ranks slots0-2={2,1,3}, samples={10,5,20}, use_median=1.
- Result: out_data=10, out_err=0, 2 cycles after handshake.
REQ-035 SHALL cover explicit rank selection:
- k=11, ranks={7,6,5,4,3,2,1}, use_median=0, rank_sel=7.
- Result: out_data=slot0 sample, out_err=0.
REQ-036 SHALL cover an out-of-range target:
- k=01 (W=5), rank_sel=6.
- Result: out_data=0, out_err=1; with macro defined, err_cnt=1 after handshake.
REQ-037 SHALL cover a duplicate rank:
- Slots 1 and 3 both rank 2, target 2.
- Result: slot 1 sample out, out_err=1.
REQ-038 SHALL cover backpressure:
- out_ready low for 5 cycles while 3 sets are offered.
- in_ready drops after 2 accepted.
- Outputs emerge in order, stable while stalled, none lost or duplicated.
REQ-039 SHALL cover reset with the pipeline full:
- Assert rst while both stages are full.
- Result: out_valid=0 immediately; no stale output after release.

Source files
------------

// File: rtl/wos_pkg.sv
// Shared helpers for the rank-select block: the default rank-field width,
// the active window size from the thermometer control, and the median target.
package wos_pkg;

  // The rank field holds 0 ("inactive") plus the ranks 1..n.
  function automatic int rank_width(input int n);
    return $clog2(n + 1);
  endfunction

  // W = 3 + 2 * popcount(k). The caller zero-extends k to 32 bits.
  function automatic int window_size(input logic [31:0] k);
    int cnt;
    cnt = 0;
    for (int i = 0; i < 32; i++) begin
      cnt += int'(k[i]);
    end
    return 3 + 2 * cnt;
  endfunction

  // The middle rank of an odd window.
  function automatic int median_target(input int w);
    return (w + 1) / 2;
  endfunction

endpackage

// File: rtl/rank_match.sv
// rank_match: builds the one-hot match of per-slot ranks against the target,
// and does the priority (lowest index) select over a registered match vector.
// Match generation and selection sit on opposite sides of a pipeline register
// in the parent, so they have separate inputs.
module rank_match #(
  parameter int DATA_BITS = 8,
  parameter int N         = 7,
  parameter int RANK_BITS = 3
) (
  input  logic [RANK_BITS*N-1:0] ranks,
  input  logic [RANK_BITS-1:0]   target,
  output logic [N-1:0]           match,
  input  logic [N-1:0]           sel_match,
  input  logic [DATA_BITS*N-1:0] sel_samples,
  output logic [DATA_BITS-1:0]   sel_data,
  output logic                   any_match,
  output logic                   multi_match
);

  // One comparator per slot; rank 0 marks an inactive slot and never matches.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_cmp
      assign match[gi] = (ranks[gi*RANK_BITS +: RANK_BITS] == target) && (target != '0);
    end
  endgenerate

  // Walk from the top slot down so the lowest-index match wins.
  always_comb begin
    sel_data = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (sel_match[i]) sel_data = sel_samples[i*DATA_BITS +: DATA_BITS];
    end
  end

  // More than one bit set exactly when clearing the lowest set bit leaves something.
  assign any_match   = |sel_match;
  assign multi_match = |(sel_match & (sel_match - N'(1)));

endmodule

// File: rtl/rank_select.sv
// rank_select: picks the sample whose rank equals a target rank (the window
// median or an explicit rank) through a two-stage valid/ready pipeline.
// Optional macro RANK_SELECT_ERR_CNT_EN adds a saturating 8-bit err_cnt output
// that counts output handshakes carrying out_err.
module rank_select
  import wos_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int N         = 7,
  parameter int RANK_BITS = rank_width(N)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [RANK_BITS*N-1:0] ranks,
  input  logic [DATA_BITS*N-1:0] samples,
  input  logic [(N-3)/2-1:0]     k,
  input  logic                   use_median,
  input  logic [RANK_BITS-1:0]   rank_sel,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_BITS-1:0]   out_data,
  output logic                   out_err
`ifdef RANK_SELECT_ERR_CNT_EN
  ,
  output logic [7:0]             err_cnt
`endif
);

  logic                   a_valid_reg;
  logic [N-1:0]           a_match_reg;
  logic [DATA_BITS*N-1:0] a_samples_reg;
  logic                   a_err_reg;
  logic                   b_valid_reg;
  logic [DATA_BITS-1:0]   b_data_reg;
  logic                   b_err_reg;

  logic                   a_ready;
  logic                   b_ready;
  int                     w_val;
  int                     target_full;
  logic [RANK_BITS-1:0]   target;
  logic                   range_err;
  logic [N-1:0]           match_next;
  logic [DATA_BITS-1:0]   sel_data;
  logic                   any_match;
  logic                   multi_match;
  logic [DATA_BITS-1:0]   b_data_next;
  logic                   b_err_next;

  // A stage may load when it is empty or its contents move on this cycle.
  assign b_ready  = !b_valid_reg || out_ready;
  assign a_ready  = !a_valid_reg || b_ready;
  assign in_ready = a_ready;

  // Target rank and range check, from the controls presented with the set.
  always_comb begin
    w_val = window_size(32'(k));
    if (use_median) target_full = median_target(w_val);
    else            target_full = int'(rank_sel);
    target    = target_full[RANK_BITS-1:0];
    range_err = (target_full == 0) || (target_full > w_val);
  end

  rank_match #(
    .DATA_BITS (DATA_BITS),
    .N         (N),
    .RANK_BITS (RANK_BITS)
  ) u_match (
    .ranks       (ranks),
    .target      (target),
    .match       (match_next),
    .sel_match   (a_match_reg),
    .sel_samples (a_samples_reg),
    .sel_data    (sel_data),
    .any_match   (any_match),
    .multi_match (multi_match)
  );

  // A duplicate still delivers the chosen sample; no match or a bad target zeroes it.
  always_comb begin
    b_err_next  = a_err_reg || !any_match || multi_match;
    b_data_next = (a_err_reg || !any_match) ? '0 : sel_data;
  end

  // Stage A: capture match vector, samples and range error on an accepted set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_valid_reg   <= 1'b0;
      a_match_reg   <= '0;
      a_samples_reg <= '0;
      a_err_reg     <= 1'b0;
    end else if (a_ready) begin
      a_valid_reg <= in_valid;
      if (in_valid) begin
        a_match_reg   <= match_next;
        a_samples_reg <= samples;
        a_err_reg     <= range_err;
      end
    end
  end

  // Stage B: hold the selected result until the consumer takes it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      b_valid_reg <= 1'b0;
      b_data_reg  <= '0;
      b_err_reg   <= 1'b0;
    end else if (b_ready) begin
      b_valid_reg <= a_valid_reg;
      if (a_valid_reg) begin
        b_data_reg <= b_data_next;
        b_err_reg  <= b_err_next;
      end
    end
  end

  assign out_valid = b_valid_reg;
  assign out_data  = b_data_reg;
  assign out_err   = b_err_reg;

`ifdef RANK_SELECT_ERR_CNT_EN
  logic [7:0] err_cnt_reg;

  // Count delivered error results, sticking at 255.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_cnt_reg <= 8'd0;
    end else if (b_valid_reg && out_ready && b_err_reg && (err_cnt_reg != 8'hFF)) begin
      err_cnt_reg <= err_cnt_reg + 8'd1;
    end
  end

  assign err_cnt = err_cnt_reg;
`endif

endmodule

// File: tb/tb_rank_select.sv
// Testbench for rank_select (N=7, DATA_BITS=8). Stimulus pushes the
// hand-computed result into a scoreboard queue; a monitor pops and compares
// on each output handshake.
module tb_rank_select;

  localparam int DB = 8;
  localparam int NN = 7;
  localparam int RB = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [RB*NN-1:0] ranks = '0;
  logic [DB*NN-1:0] samples = '0;
  logic [1:0]     k = '0;
  logic           use_median = 1'b0;
  logic [RB-1:0]  rank_sel = '0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [DB-1:0]  out_data;
  logic           out_err;
`ifdef RANK_SELECT_ERR_CNT_EN
  logic [7:0]     err_cnt;
  int             exp_cnt = 0;
`endif

  typedef struct packed {
    logic [DB-1:0] d;
    logic          e;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   accepts = 0;
  int   stalls;

  rank_select #(.DATA_BITS(DB), .N(NN), .RANK_BITS(RB)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ranks      (ranks),
    .samples    (samples),
    .k          (k),
    .use_median (use_median),
    .rank_sel   (rank_sel),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_err    (out_err)
`ifdef RANK_SELECT_ERR_CNT_EN
    ,
    .err_cnt    (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Offer one set; record the expected result at the handshake edge.
  task automatic send(input string name, input logic [1:0] kk, input logic um,
                      input logic [RB-1:0] rs, input int r[7], input int s[7],
                      input logic [DB-1:0] exp_d, input logic exp_e);
    exp_t ex;
    int   wait_cnt;
    @(negedge clk);
    for (int i = 0; i < NN; i++) begin
      ranks[i*RB +: RB]   = RB'(r[i]);
      samples[i*DB +: DB] = DB'(s[i]);
    end
    k = kk; use_median = um; rank_sel = rs; in_valid = 1'b1;
    #1;
    wait_cnt = 0;
    while (!in_ready && wait_cnt < 50) begin
      @(negedge clk); #1;
      wait_cnt++;
    end
    stalls = wait_cnt;
    if (!in_ready) begin
      errors++; checks++;
      $display("FAIL %s: in_ready never rose (got 0 expected 1)", name);
      in_valid = 1'b0;
    end else begin
      ex.d = exp_d; ex.e = exp_e;
      sb.push_back(ex);
      accepts++;
      $display("SEND %s k=%b med=%b sel=%0d exp_data=%0d exp_err=%b", name, kk, um, rs, exp_d, exp_e);
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  // Monitor: compare on each handshake, and check stability while stalled.
  logic          held_v = 1'b0;
  logic [DB-1:0] held_d;
  logic          held_e;
  initial begin
    exp_t ex;
    forever begin
      @(negedge clk); #2;
      if (!rst) begin
        held_v = 1'b0;
      end else if (out_valid) begin
        if (held_v) begin
          checks++;
          if (out_data !== held_d || out_err !== held_e) begin
            errors++;
            $display("FAIL stall_hold: got data=%0d err=%b expected data=%0d err=%b", out_data, out_err, held_d, held_e);
          end
        end
        if (out_ready) begin
          held_v = 1'b0;
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output: got data=%0d err=%b expected no output", out_data, out_err);
          end else begin
            ex = sb.pop_front();
            if (out_data !== ex.d || out_err !== ex.e) begin
              errors++;
              $display("FAIL result: got data=%0d err=%b expected data=%0d err=%b", out_data, out_err, ex.d, ex.e);
            end else begin
              $display("RECV data=%0d err=%b", out_data, out_err);
            end
`ifdef RANK_SELECT_ERR_CNT_EN
            check("err_cnt", int'(err_cnt), exp_cnt);
            if (ex.e && exp_cnt < 255) exp_cnt++;
`endif
          end
        end else begin
          held_v = 1'b1; held_d = out_data; held_e = out_err;
        end
      end else begin
        held_v = 1'b0;
      end
    end
  end

  initial begin
    int r_rev[7] = '{7, 6, 5, 4, 3, 2, 1};
    int s_seq[7] = '{11, 22, 33, 44, 55, 66, 77};
    int z7[7]    = '{0, 0, 0, 0, 0, 0, 0};
    int wait_cnt;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_out_data", int'(out_data), 0);
    check("reset_out_err", int'(out_err), 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("ready_after_reset", int'(in_ready), 1);

    // Basic median with latency check: W=3, target 2 -> slot0 (10)
    out_ready = 1'b1;
    send("median_w3", 2'b00, 1'b1, 3'd0, '{2, 1, 3, 0, 0, 0, 0}, '{10, 5, 20, 0, 0, 0, 0}, 8'd10, 1'b0);
    check("latency_cycle1_valid", int'(out_valid), 0);
    @(posedge clk); #1;
    check("latency_cycle2_valid", int'(out_valid), 1);

    // Explicit rank 7 with W=7 -> slot0
    send("explicit_r7", 2'b11, 1'b0, 3'd7, r_rev, s_seq, 8'd11, 1'b0);
    // Target 6 beyond W=5 -> zero with error
    send("out_of_range", 2'b01, 1'b0, 3'd6, r_rev, s_seq, 8'd0, 1'b1);
    // Slots 1 and 3 both rank 2 -> slot1 sample, error
    send("duplicate", 2'b11, 1'b0, 3'd2, '{1, 2, 3, 2, 4, 5, 6}, '{1, 2, 3, 4, 5, 6, 7}, 8'd2, 1'b1);
    // Median of W=5 is 3 -> slot2 (30)
    send("median_w5", 2'b10, 1'b1, 3'd0, '{5, 4, 3, 2, 1, 0, 0}, '{50, 40, 30, 20, 10, 0, 0}, 8'd30, 1'b0);

    // Back-to-back sets with out_ready high: no stalls expected
    send("median_w7", 2'b11, 1'b1, 3'd0, r_rev, s_seq, 8'd44, 1'b0);
    check("tput_stall0", stalls, 0);
    send("no_match", 2'b00, 1'b1, 3'd0, '{1, 3, 0, 0, 0, 0, 0}, '{9, 8, 7, 6, 5, 4, 3}, 8'd0, 1'b1);
    check("tput_stall1", stalls, 0);
    send("target_zero", 2'b11, 1'b0, 3'd0, z7, s_seq, 8'd0, 1'b1);
    check("tput_stall2", stalls, 0);
    send("last_slot", 2'b11, 1'b0, 3'd1, r_rev, s_seq, 8'd77, 1'b0);
    check("tput_stall3", stalls, 0);

    // Backpressure: out_ready low for 5 cycles while 3 sets are offered
    repeat (4) @(posedge clk);
    accepts = 0;
    @(negedge clk);
    out_ready = 1'b0;
    fork
      begin
        send("bp_a", 2'b00, 1'b1, 3'd0, '{2, 1, 3, 0, 0, 0, 0}, '{10, 5, 20, 0, 0, 0, 0}, 8'd10, 1'b0);
        send("bp_b", 2'b11, 1'b0, 3'd7, r_rev, s_seq, 8'd11, 1'b0);
        send("bp_c", 2'b01, 1'b0, 3'd6, r_rev, s_seq, 8'd0, 1'b1);
      end
      begin
        repeat (3) @(negedge clk);
        #1;
        check("bp_accepted_before_stall", accepts, 2);
        check("bp_in_ready_low", int'(in_ready), 0);
        repeat (2) @(negedge clk);
        out_ready = 1'b1;
      end
    join
    wait_cnt = 0;
    while (sb.size() != 0 && wait_cnt < 50) begin
      @(posedge clk);
      wait_cnt++;
    end
    check("bp_drained", sb.size(), 0);

    // Reset with both stages full: in-flight sets are discarded
    @(negedge clk);
    out_ready = 1'b0;
    send("rst_x", 2'b11, 1'b0, 3'd3, r_rev, s_seq, 8'd55, 1'b0);
    send("rst_y", 2'b11, 1'b0, 3'd4, r_rev, s_seq, 8'd44, 1'b0);
    check("full_in_ready_low", int'(in_ready), 0);
    check("full_out_valid", int'(out_valid), 1);
    rst = 1'b0;
    #1;
    check("rst_out_valid_now", int'(out_valid), 0);
    sb.delete();
`ifdef RANK_SELECT_ERR_CNT_EN
    exp_cnt = 0;
`endif
    repeat (2) @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    #1;
    check("rst_release_ready", int'(in_ready), 1);
    repeat (6) @(posedge clk);
    #1;
    check("no_stale_output", int'(out_valid), 0);

    // Pipeline works again after reset
    send("post_rst", 2'b10, 1'b1, 3'd0, '{5, 4, 3, 2, 1, 0, 0}, '{50, 40, 30, 20, 10, 0, 0}, 8'd30, 1'b0);
    wait_cnt = 0;
    while (sb.size() != 0 && wait_cnt < 50) begin
      @(posedge clk);
      wait_cnt++;
    end
    check("final_drained", sb.size(), 0);
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
